// File: rtl/vls_pkg.sv
// Shared encodings for the vehicle lane sequencer: FSM state values and the
// select codes understood by the per-bit 4:1 lane multiplexers.
package vls_pkg;

    localparam logic [1:0] VLS_IDLE   = 2'd0;
    localparam logic [1:0] VLS_RUN    = 2'd1;
    localparam logic [1:0] VLS_PAUSED = 2'd2;
    localparam logic [1:0] VLS_LOAD   = 2'd3;

    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_LEFT  = 2'd1;
    localparam logic [1:0] SEL_RIGHT = 2'd2;
    localparam logic [1:0] SEL_LOAD  = 2'd3;

endpackage

// File: rtl/vls_prescaler.sv
// Shift-period counter: counts up while advanced, wraps at the effective period
// and flags the terminal count. A speed of 0 behaves as 1.
module vls_prescaler #(
    parameter int unsigned PRESCALER_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       advance,
    input  logic [PRESCALER_WIDTH-1:0] speed,
    output logic                       terminal
);

    logic [PRESCALER_WIDTH-1:0] count_q;
    logic [PRESCALER_WIDTH-1:0] speed_eff;

    assign speed_eff = (speed == '0) ? PRESCALER_WIDTH'(1) : speed;
    // >= so that a speed reduced below the current count wraps immediately
    assign terminal  = (count_q >= (speed_eff - PRESCALER_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (advance) begin
            count_q <= terminal ? '0 : count_q + PRESCALER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/vehicle_lane_sequencer.sv
// Lane control FSM: drives the shared select bus of the lane muxes (hold,
// shift, load) from enable/pause levels, the prescaler and a load handshake.
module vehicle_lane_sequencer
    import vls_pkg::*;
#(
    parameter int unsigned DATAWIDTH_SELECTOR = 2,
    parameter int unsigned PRESCALER_WIDTH    = 24,
    parameter int unsigned LANE_DIRECTION     = 0
) (
    input  logic                          VLS_CLOCK_50,
    input  logic                          VLS_RESET_InLow,
    input  logic                          VLS_ENABLE_IN,
    input  logic                          VLS_PAUSE_IN,
    input  logic [PRESCALER_WIDTH-1:0]    VLS_SPEED_IN,
    input  logic                          VLS_LOAD_REQ_IN,
    output logic [DATAWIDTH_SELECTOR-1:0] VLS_SELECT_BUS_OUT,
    output logic                          VLS_SHIFT_STROBE_OUT,
    output logic                          VLS_LOAD_ACK_OUT,
    output logic [1:0]                    VLS_STATE_OUT
);

    localparam logic [DATAWIDTH_SELECTOR-1:0] SEL_HOLD_W  = DATAWIDTH_SELECTOR'(SEL_HOLD);
    localparam logic [DATAWIDTH_SELECTOR-1:0] SEL_LOAD_W  = DATAWIDTH_SELECTOR'(SEL_LOAD);
    localparam logic [DATAWIDTH_SELECTOR-1:0] SHIFT_CODE  = (LANE_DIRECTION == 0) ?
        DATAWIDTH_SELECTOR'(SEL_LEFT) : DATAWIDTH_SELECTOR'(SEL_RIGHT);

    logic [1:0]                    state_q, state_d;
    logic [DATAWIDTH_SELECTOR-1:0] select_q, select_d;
    logic                          strobe_q, ack_q;
    logic                          load_prev_q;
    logic                          load_edge;
    logic                          cnt_clear, cnt_advance, cnt_terminal;

    assign load_edge = VLS_LOAD_REQ_IN & ~load_prev_q;

    vls_prescaler #(
        .PRESCALER_WIDTH(PRESCALER_WIDTH)
    ) u_prescaler (
        .clk     (VLS_CLOCK_50),
        .rst_n   (VLS_RESET_InLow),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .speed   (VLS_SPEED_IN),
        .terminal(cnt_terminal)
    );

    always_comb begin
        state_d     = state_q;
        select_d    = SEL_HOLD_W;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        case (state_q)
            VLS_IDLE: begin
                cnt_clear = 1'b1;
                if (load_edge) begin
                    state_d  = VLS_LOAD;
                    select_d = SEL_LOAD_W;
                end else if (VLS_ENABLE_IN) begin
                    state_d = VLS_RUN;
                end
            end
            VLS_RUN: begin
                if (load_edge) begin
                    state_d   = VLS_LOAD;
                    select_d  = SEL_LOAD_W;
                    cnt_clear = 1'b1;
                end else if (!VLS_ENABLE_IN) begin
                    state_d   = VLS_IDLE;
                    cnt_clear = 1'b1;
                end else if (VLS_PAUSE_IN) begin
                    state_d = VLS_PAUSED;
                end else begin
                    cnt_advance = 1'b1;
                    if (cnt_terminal) begin
                        select_d = SHIFT_CODE;
                    end
                end
            end
            VLS_PAUSED: begin
                if (load_edge) begin
                    state_d   = VLS_LOAD;
                    select_d  = SEL_LOAD_W;
                    cnt_clear = 1'b1;
                end else if (!VLS_ENABLE_IN) begin
                    state_d   = VLS_IDLE;
                    cnt_clear = 1'b1;
                end else if (!VLS_PAUSE_IN) begin
                    state_d = VLS_RUN;
                end
            end
            default: begin
                // LOAD lasts one cycle; edges seen here are deliberately dropped
                cnt_clear = 1'b1;
                state_d   = VLS_ENABLE_IN ? VLS_RUN : VLS_IDLE;
            end
        endcase
    end

    always_ff @(posedge VLS_CLOCK_50) begin
        if (!VLS_RESET_InLow) begin
            state_q     <= VLS_IDLE;
            select_q    <= SEL_HOLD_W;
            strobe_q    <= 1'b0;
            ack_q       <= 1'b0;
            load_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            select_q    <= select_d;
            strobe_q    <= (select_d == SHIFT_CODE);
            ack_q       <= (select_d == SEL_LOAD_W);
            load_prev_q <= VLS_LOAD_REQ_IN;
        end
    end

    assign VLS_SELECT_BUS_OUT   = select_q;
    assign VLS_SHIFT_STROBE_OUT = strobe_q;
    assign VLS_LOAD_ACK_OUT     = ack_q;
    assign VLS_STATE_OUT        = state_q;

endmodule

// File: tb/tb_vehicle_lane_sequencer.sv
// Scoreboard bench: two sequencers (left- and right-moving) share stimulus; the
// expected outputs of every cycle are queued as driven and compared after the edge.
module tb_vehicle_lane_sequencer;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSED = 2'd2, ST_LOAD = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n, en, pause, load;
    logic [23:0] speed;
    logic [1:0]  sel_l, sel_r, st_l, st_r;
    logic        stb_l, stb_r, ack_l, ack_r;

    logic [11:0] sb[$];
    logic [11:0] got, want;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    vehicle_lane_sequencer #(
        .DATAWIDTH_SELECTOR(2), .PRESCALER_WIDTH(24), .LANE_DIRECTION(0)
    ) dut_left (
        .VLS_CLOCK_50(clk), .VLS_RESET_InLow(rst_n), .VLS_ENABLE_IN(en),
        .VLS_PAUSE_IN(pause), .VLS_SPEED_IN(speed), .VLS_LOAD_REQ_IN(load),
        .VLS_SELECT_BUS_OUT(sel_l), .VLS_SHIFT_STROBE_OUT(stb_l),
        .VLS_LOAD_ACK_OUT(ack_l), .VLS_STATE_OUT(st_l)
    );

    vehicle_lane_sequencer #(
        .DATAWIDTH_SELECTOR(2), .PRESCALER_WIDTH(24), .LANE_DIRECTION(1)
    ) dut_right (
        .VLS_CLOCK_50(clk), .VLS_RESET_InLow(rst_n), .VLS_ENABLE_IN(en),
        .VLS_PAUSE_IN(pause), .VLS_SPEED_IN(speed), .VLS_LOAD_REQ_IN(load),
        .VLS_SELECT_BUS_OUT(sel_r), .VLS_SHIFT_STROBE_OUT(stb_r),
        .VLS_LOAD_ACK_OUT(ack_r), .VLS_STATE_OUT(st_r)
    );

    // sel is the left-moving lane's code; the right-moving lane uses 2 where it uses 1
    function automatic logic [11:0] exp_vec(input logic [1:0] st, input logic [1:0] sel);
        logic [1:0] sr;
        sr = (sel == 2'd1) ? 2'd2 : sel;
        return {st, sel, sel == 2'd1, sel == 2'd3, st, sr, sr == 2'd2, sr == 2'd3};
    endfunction

    function automatic logic [11:0] act_vec();
        return {st_l, sel_l, stb_l, ack_l, st_r, sel_r, stb_r, ack_r};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 23; i++) begin
            rst_n = (i >= 3); en = 1'b0; pause = 1'b0; load = 1'b0; speed = 24'd4;
            sb.push_back(exp_vec(ST_IDLE, 2'd0));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    // i = -1 is an idle cycle; ENABLE sampled high at cycle 0
    task automatic test_shift_period();
        for (int i = -1; i < 14; i++) begin
            en = (i >= 0); speed = 24'd4;
            sb.push_back(exp_vec(i < 0 ? ST_IDLE : ST_RUN,
                                 (i > 0 && i % 4 == 0) ? 2'd1 : 2'd0));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL shift_period cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_speed_zero();
        for (int i = -1; i < 7; i++) begin
            en = (i >= 0); speed = 24'd0;
            sb.push_back(exp_vec(i < 0 ? ST_IDLE : ST_RUN, (i >= 1) ? 2'd1 : 2'd0));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL speed_zero cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    // counter sits at 7 in cycle 7; speed drops to 2 for edge 8
    task automatic test_speed_change();
        for (int i = -1; i < 15; i++) begin
            en = (i >= 0); speed = (i >= 8) ? 24'd2 : 24'd10;
            sb.push_back(exp_vec(i < 0 ? ST_IDLE : ST_RUN,
                                 (i >= 8 && i % 2 == 0) ? 2'd1 : 2'd0));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL speed_change cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    // request held high for edges 2..6 -> single LOAD in cycle 2, RUN restarts at 3
    task automatic test_load_held();
        for (int i = -1; i < 13; i++) begin
            en = (i >= 0); speed = 24'd4; load = (i >= 2 && i <= 6);
            sb.push_back(exp_vec(i < 0 ? ST_IDLE : (i == 2 ? ST_LOAD : ST_RUN),
                                 i == 2 ? 2'd3 : ((i == 7 || i == 11) ? 2'd1 : 2'd0)));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_held cyc%0d got=%h want=%h", i, got, want);
            end
        end
        load = 1'b0;
    endtask

    // pause for edges 3..8 with counter at 2; resumes at 2 -> strobe 3 cycles later
    task automatic test_pause();
        for (int i = -1; i < 18; i++) begin
            en = (i >= 0); speed = 24'd5; pause = (i >= 3 && i <= 8);
            sb.push_back(exp_vec(i < 0 ? ST_IDLE : ((i >= 3 && i <= 8) ? ST_PAUSED : ST_RUN),
                                 (i == 12 || i == 17) ? 2'd1 : 2'd0));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL pause cyc%0d got=%h want=%h", i, got, want);
            end
        end
        pause = 1'b0;
    endtask

    // load from IDLE with enable low/high, LOAD exit depends on ENABLE
    task automatic test_back_to_back();
        logic [1:0] st_tab[6]  = '{ST_IDLE, ST_LOAD, ST_IDLE, ST_LOAD, ST_RUN, ST_RUN};
        logic [1:0] sel_tab[6] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
        logic       en_tab[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       ld_tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            en = en_tab[i]; load = ld_tab[i]; speed = 24'd4;
            sb.push_back(exp_vec(st_tab[i], sel_tab[i]));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back step%0d got=%h want=%h", i, got, want);
            end
        end
        load = 1'b0;
    endtask

    // load edge on the terminal-count edge, then reset during LOAD
    task automatic test_load_terminal_reset();
        for (int i = -1; i < 8; i++) begin
            en = (i >= 0 && i <= 3); speed = 24'd3; load = (i == 3); rst_n = !(i == 4);
            sb.push_back(exp_vec((i >= 0 && i <= 2) ? ST_RUN : (i == 3 ? ST_LOAD : ST_IDLE),
                                 i == 3 ? 2'd3 : 2'd0));
            @(posedge clk); #1;
            got = act_vec(); want = sb.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_terminal_reset cyc%0d got=%h want=%h", i, got, want);
            end
        end
        rst_n = 1'b1; load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pause = 1'b0; load = 1'b0; speed = 24'd4;
        #1;
        test_reset();
        test_shift_period();
        test_speed_zero();
        test_speed_change();
        test_load_held();
        test_pause();
        test_back_to_back();
        test_load_terminal_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
